axi4_lite_master_arb: RTL and testbench
=======================================

AXI4_LITE_MASTER_ARB -- requirements
Module: axi4_lite_master_arb

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; minimum 2.
- PROT_VALUE, 3'b000, value driven on AW_PROT/AR_PROT.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- i_wr_req  in  1  write request.
- i_rd_req  in  1  read request.
- i_addr  in  AXI_ADDR_WIDTH  request address.
- i_wdata  in  AXI_DATA_WIDTH  write data.
- i_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
- o_req_ready  out  1  high only in IDLE; a request is accepted when a req and o_req_ready are both high.
- o_rdata  out  AXI_DATA_WIDTH  last read data.
- o_resp  out  2  last B_RESP/R_RESP.
- o_done  out  1  one-cycle completion pulse.
- o_fault  out  1  one-cycle pulse with o_done when resp != 2'b00.
- o_timeout  out  1  sticky timeout flag.
- AXI4-Lite master ports AW_*, W_*, B_*, AR_*, R_*: standard directions and widths.

Function
REQ-003 The FSM SHALL have states IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA, ERR.
REQ-004 On acceptance, i_addr, i_wdata and i_wstrb SHALL be registered; AXI outputs SHALL be driven only from registers.
REQ-005 If i_wr_req and i_rd_req are both high in IDLE, the block SHALL arbitrate round-robin: first-ever conflict goes to read; each later conflict goes to the type not granted at the previous conflict. Non-conflicting requests SHALL NOT change the round-robin pointer.
REQ-006 Write acceptance SHALL enter WR with AW_VALID=1 and W_VALID=1 on the next cycle.
REQ-007 In WR, each valid SHALL drop independently the cycle after its own ready handshake; AW and W SHALL complete in either order or together. WR SHALL exit to WR_RESP once both are done.
REQ-008 B_READY SHALL be high only in WR_RESP. On B_VALID&B_READY: latch o_resp=B_RESP, pulse o_done (plus o_fault if nonzero), return to IDLE.
REQ-009 Read acceptance SHALL enter RD_ADDR with AR_VALID=1. On AR_READY, go to RD_DATA with R_READY=1.
REQ-010 On R_VALID&R_READY: latch o_rdata=R_DATA and o_resp=R_RESP, pulse o_done (plus o_fault if nonzero), return to IDLE.
REQ-011 Valids SHALL NOT be withdrawn before their handshake, except by reset.
REQ-012 Minimum latency, acceptance to o_done, SHALL be 3 cycles, with all readies high and responses returned the cycle after the address.
REQ-013 A counter SHALL clear on acceptance and increment in every non-IDLE, non-ERR cycle. On reaching TIMEOUT_CYCLES-1 without completion, the block SHALL:
- enter ERR and set o_timeout;
- pulse o_done and o_fault with o_resp=2'b10.
REQ-014 In ERR, the block SHALL keep all valids/readies low and o_req_ready low until reset.
REQ-015 Completion and timeout in the same cycle SHALL resolve as completion.
REQ-016 A request SHALL never be accepted in the same cycle as an o_done pulse.
REQ-017 AW_PROT and AR_PROT SHALL equal PROT_VALUE at all times.

Reset
REQ-018 With rst_n low at a clk edge, the block SHALL enter IDLE and clear all valids, readies, o_done, o_fault, o_timeout, o_rdata, o_resp, the counter and the round-robin pointer (next conflict goes to read). Reset SHALL take effect mid-transaction, with no completion pulse.

Verification
REQ-019 Write with addr=0x1000, data=0xDEADBEEF, strb=4'hF; AW_READY 2 cycles before W_READY; B_RESP=0 -> AW_ADDR=0x1000, W_DATA=0xDEADBEEF, one o_done, o_fault=0.
REQ-020 Read with addr=0x2004; R_DATA=0x12345678, R_RESP=2'b10 -> o_rdata=0x12345678, o_resp=2'b10, o_done and o_fault pulse together.
REQ-021 i_wr_req and i_rd_req held high for 4 consecutive grants -> order R, W, R, W.
REQ-022 TIMEOUT_CYCLES=8; AW_READY held low -> o_timeout set at cycle 7 after acceptance; ERR persists; o_req_ready=0 until rst_n pulse.
REQ-023 rst_n low while in RD_DATA -> next cycle all outputs at reset values, no o_done; a subsequent read completes normally.
REQ-024 All-ready zero-wait write -> o_done exactly 3 cycles after acceptance; i_wstrb=4'b0101 appears on W_STRB.

Source files
------------

// File: rtl/axi4_lite_master_arb.sv
// AXI4-Lite single-outstanding master with read/write round-robin arbitration.
// One request at a time: a watchdog aborts stuck transactions into a locked error state.
module axi4_lite_master_arb #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  PROT_VALUE     = 3'b000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_req,
    input  logic                          i_rd_req,
    input  logic [AXI_ADDR_WIDTH-1:0]     i_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   i_wstrb,
    output logic                          o_req_ready,
    output logic [AXI_DATA_WIDTH-1:0]     o_rdata,
    output logic [1:0]                    o_resp,
    output logic                          o_done,
    output logic                          o_fault,
    output logic                          o_timeout,
    output logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR,
    output logic [2:0]                    AW_PROT,
    output logic                          AW_VALID,
    input  logic                          AW_READY,
    output logic [AXI_DATA_WIDTH-1:0]     W_DATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   W_STRB,
    output logic                          W_VALID,
    input  logic                          W_READY,
    input  logic [1:0]                    B_RESP,
    input  logic                          B_VALID,
    output logic                          B_READY,
    output logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR,
    output logic [2:0]                    AR_PROT,
    output logic                          AR_VALID,
    input  logic                          AR_READY,
    input  logic [AXI_DATA_WIDTH-1:0]     R_DATA,
    input  logic [1:0]                    R_RESP,
    input  logic                          R_VALID,
    output logic                          R_READY
);

    localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_ERR
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]         strb_q, strb_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      b_ready_q, b_ready_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      r_ready_q, r_ready_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      rr_q, rr_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      done_q, done_d;
    logic                      fault_q, fault_d;
    logic                      timeout_q, timeout_d;

    logic                      grant_wr;
    logic                      grant_rd;
    logic                      busy;
    logic                      complete;
    logic [CNT_W-1:0]          cnt_inc;

    // Next-state, arbitration, handshake tracking and watchdog abort.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        timeout_d  = timeout_q;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        busy       = 1'b0;
        complete   = 1'b0;
        cnt_inc    = cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                // no acceptance while the completion pulse is still showing
                if (!done_q) begin
                    grant_wr = i_wr_req && (!i_rd_req || rr_q);
                    grant_rd = i_rd_req && (!i_wr_req || !rr_q);
                    if (i_wr_req && i_rd_req) begin
                        rr_d = !rr_q;
                    end
                    if (grant_wr) begin
                        addr_d     = i_addr;
                        wdata_d    = i_wdata;
                        strb_d     = i_wstrb;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_WR;
                    end else if (grant_rd) begin
                        addr_d     = i_addr;
                        ar_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                busy       = 1'b1;
                aw_valid_d = aw_valid_q && !AW_READY;
                w_valid_d  = w_valid_q && !W_READY;
                if (!aw_valid_d && !w_valid_d) begin
                    b_ready_d = 1'b1;
                    state_d   = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                busy = 1'b1;
                if (B_VALID) begin
                    complete  = 1'b1;
                    b_ready_d = 1'b0;
                    resp_d    = B_RESP;
                    done_d    = 1'b1;
                    fault_d   = |B_RESP;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                busy = 1'b1;
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                busy = 1'b1;
                if (R_VALID) begin
                    complete  = 1'b1;
                    r_ready_d = 1'b0;
                    rdata_d   = R_DATA;
                    resp_d    = R_RESP;
                    done_d    = 1'b1;
                    fault_d   = |R_RESP;
                    state_d   = S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // watchdog: a completion on the final cycle still wins
        if (busy) begin
            cnt_d = cnt_inc;
            if (!complete && cnt_inc == CNT_LAST) begin
                state_d    = S_ERR;
                aw_valid_d = 1'b0;
                w_valid_d  = 1'b0;
                b_ready_d  = 1'b0;
                ar_valid_d = 1'b0;
                r_ready_d  = 1'b0;
                timeout_d  = 1'b1;
                done_d     = 1'b1;
                fault_d    = 1'b1;
                resp_d     = 2'b10;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE) && !done_q;
    assign o_rdata     = rdata_q;
    assign o_resp      = resp_q;
    assign o_done      = done_q;
    assign o_fault     = fault_q;
    assign o_timeout   = timeout_q;

    assign AW_ADDR  = addr_q;
    assign AW_PROT  = PROT_VALUE;
    assign AW_VALID = aw_valid_q;
    assign W_DATA   = wdata_q;
    assign W_STRB   = strb_q;
    assign W_VALID  = w_valid_q;
    assign B_READY  = b_ready_q;
    assign AR_ADDR  = addr_q;
    assign AR_PROT  = PROT_VALUE;
    assign AR_VALID = ar_valid_q;
    assign R_READY  = r_ready_q;

endmodule

// File: tb/tb_axi4_lite_master_arb.sv
// Bench for axi4_lite_master_arb: scheduled AXI slave plus a transaction-level
// reference model (arbitration pointer, latency arithmetic, timeout rule).
module tb_axi4_lite_master_arb;

    localparam int         AW   = 64;
    localparam int         DW   = 32;
    localparam int         SW   = DW / 8;
    localparam int         TMO  = 8;
    localparam logic [2:0] PROT = 3'b101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_wr_req, i_rd_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [SW-1:0] i_wstrb;
    logic          o_req_ready;
    logic [DW-1:0] o_rdata;
    logic [1:0]    o_resp;
    logic          o_done, o_fault, o_timeout;
    logic [AW-1:0] AW_ADDR;
    logic [2:0]    AW_PROT;
    logic          AW_VALID, AW_READY;
    logic [DW-1:0] W_DATA;
    logic [SW-1:0] W_STRB;
    logic          W_VALID, W_READY;
    logic [1:0]    B_RESP;
    logic          B_VALID, B_READY;
    logic [AW-1:0] AR_ADDR;
    logic [2:0]    AR_PROT;
    logic          AR_VALID, AR_READY;
    logic [DW-1:0] R_DATA;
    logic [1:0]    R_RESP;
    logic          R_VALID, R_READY;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit            rr_m;
    logic [DW-1:0] rdata_m;
    logic [1:0]    resp_m;

    always #5 clk = ~clk;

    axi4_lite_master_arb #(
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO),
        .PROT_VALUE(PROT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_wr_req(i_wr_req), .i_rd_req(i_rd_req),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_req_ready(o_req_ready), .o_rdata(o_rdata), .o_resp(o_resp),
        .o_done(o_done), .o_fault(o_fault), .o_timeout(o_timeout),
        .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_VALID(AW_VALID),
        .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID),
        .W_READY(W_READY),
        .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_VALID(AR_VALID),
        .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID),
        .R_READY(R_READY)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        AW_READY = 1'b0;
        W_READY  = 1'b0;
        B_VALID  = 1'b0;
        B_RESP   = 2'b00;
        AR_READY = 1'b0;
        R_VALID  = 1'b0;
        R_RESP   = 2'b00;
        R_DATA   = '0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_hs"}, 64'({AW_VALID, W_VALID, B_READY, AR_VALID,
                              R_READY, o_done, o_fault, o_timeout}), 64'(0));
        chk({tag, "_rdata"}, 64'(o_rdata), 64'(0));
        chk({tag, "_resp"}, 64'(o_resp), 64'(0));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
        slave_idle();
        step();
        check_reset_state("reset");
        step();
        rst_n   = 1'b1;
        rr_m    = 1'b0;
        rdata_m = '0;
        resp_m  = 2'b00;
        step();
        chk("reset_ready", 64'(o_req_ready), 64'(1));
    endtask

    // One request through to completion or timeout. Delays count the cycles
    // a valid/ready is held before the slave answers.
    task automatic txn(input bit wr, input bit rd, input bit hold,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s,
                       input int aw_d, input int w_d, input int b_d,
                       input int ar_d, input int r_d,
                       input logic [1:0] rsp, input logic [DW-1:0] rdat);
        bit         gw;
        bit         tmo;
        int         wl, n, lim, waitc;
        logic [6:0] ev;
        i_wr_req = wr;
        i_rd_req = rd;
        i_addr   = a;
        i_wdata  = d;
        i_wstrb  = s;
        waitc    = 0;
        while (o_req_ready !== 1'b1 && waitc < 20) begin
            step();
            waitc++;
        end
        chk("req_ready_wait", 64'(o_req_ready), 64'(1));
        if (wr && rd) begin
            gw   = rr_m;
            rr_m = !rr_m;
        end else begin
            gw = wr;
        end
        step();
        if (!hold) begin
            i_wr_req = 1'b0;
            i_rd_req = 1'b0;
        end
        wl  = 1 + ((aw_d > w_d) ? aw_d : w_d);
        n   = gw ? (wl + 1 + b_d) : (ar_d + 2 + r_d);
        tmo = n > TMO - 1;
        lim = tmo ? TMO - 1 : n;
        for (int k = 1; k <= lim; k++) begin
            ev = {gw && k <= aw_d + 1, gw && k <= w_d + 1, gw && k > wl,
                  !gw && k <= ar_d + 1, !gw && k > ar_d + 1, 1'b0, 1'b0};
            chk("busy_handshakes",
                64'({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
                     o_req_ready, o_done}), 64'(ev));
            if (k == 1) begin
                if (gw) begin
                    chk("aw_addr", AW_ADDR, a);
                    chk("w_data", 64'(W_DATA), 64'(d));
                    chk("w_strb", 64'(W_STRB), 64'(s));
                end else begin
                    chk("ar_addr", AR_ADDR, a);
                end
            end
            AW_READY = gw && k == aw_d + 1;
            W_READY  = gw && k == w_d + 1;
            B_VALID  = gw && k == n;
            B_RESP   = rsp;
            AR_READY = !gw && k == ar_d + 1;
            R_VALID  = !gw && k == n;
            R_DATA   = rdat;
            R_RESP   = rsp;
            step();
        end
        slave_idle();
        if (tmo) begin
            resp_m = 2'b10;
        end else begin
            resp_m = rsp;
            if (!gw) rdata_m = rdat;
        end
        chk("done_pulse", 64'(o_done), 64'(1));
        chk("fault", 64'(o_fault), 64'(tmo || rsp != 2'b00));
        chk("resp", 64'(o_resp), 64'(resp_m));
        chk("rdata", 64'(o_rdata), 64'(rdata_m));
        chk("timeout", 64'(o_timeout), 64'(tmo));
        chk("ready_in_done", 64'(o_req_ready), 64'(0));
        step();
        chk("done_single", 64'({o_done, o_fault}), 64'(0));
        if (tmo) begin
            i_wr_req = 1'b1;
            for (int k = 0; k < 3; k++) begin
                chk("err_locked",
                    64'({AW_VALID, W_VALID, B_READY, AR_VALID, R_READY,
                         o_req_ready, o_timeout}), 64'(1));
                step();
            end
            do_reset();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit            wr, rd;
        logic [AW-1:0] ra;
        i_addr  = '0;
        i_wdata = '0;
        i_wstrb = '0;
        do_reset();
        chk("prot", 64'({AW_PROT, AR_PROT}), 64'({PROT, PROT}));

        // write, AW accepted two cycles before W
        txn(1, 0, 0, 64'h1000, 32'hDEADBEEF, 4'hF, 0, 2, 0, 0, 0,
            2'b00, 32'h0);
        // read returning SLVERR
        txn(0, 1, 0, 64'h2004, 32'h0, 4'h0, 0, 0, 0, 0, 0,
            2'b10, 32'h12345678);
        // zero-wait write, partial strobes
        txn(1, 0, 0, 64'h3000, 32'hA5A5A5A5, 4'b0101, 0, 0, 0, 0, 0,
            2'b00, 32'h0);

        // both requests held: R, W, R, W
        do_reset();
        txn(1, 1, 1, 64'h40, 32'h11, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h21);
        txn(1, 1, 1, 64'h44, 32'h12, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h22);
        txn(1, 1, 1, 64'h48, 32'h13, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h23);
        txn(1, 1, 0, 64'h4C, 32'h14, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h24);

        // AW never accepted: timeout, ERR lock, reset recovery
        txn(1, 0, 0, 64'h5000, 32'h55, 4'hF, 20, 0, 0, 0, 0, 2'b00, 32'h0);

        // reset while waiting in the read data phase
        txn(0, 1, 0, 64'h6000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00,
            32'hCAFEF00D);
        i_rd_req = 1'b1;
        i_addr   = 64'h7000;
        step();
        i_rd_req = 1'b0;
        AR_READY = 1'b1;
        step();
        AR_READY = 1'b0;
        chk("rd_data_phase", 64'({AR_VALID, R_READY}), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        rr_m    = 1'b0;
        rdata_m = '0;
        resp_m  = 2'b00;
        check_reset_state("mid_reset");
        chk("mid_reset_ready", 64'(o_req_ready), 64'(1));
        step();
        chk("mid_reset_nodone", 64'(o_done), 64'(0));
        txn(0, 1, 0, 64'h7008, 32'h0, 4'h0, 0, 1, 0, 1, 1, 2'b00,
            32'h0BADBEEF);

        // randomized traffic with random latencies and responses
        for (int i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            ra = {$urandom, $urandom};
            txn(wr, rd, 0, ra, $urandom, 4'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                2'($urandom), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
